// File: rtl/sdram_pkg.sv
// Shared types for sdram_initiator: FSM states, 64-bit lane map
// and watchdog counter width.
package sdram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    WAIT,
    DONE
  } state_t;

  localparam int W0_HI = 63;
  localparam int W0_LO = 48;
  localparam int W1_HI = 47;
  localparam int W1_LO = 32;
  localparam int W2_HI = 31;
  localparam int W2_LO = 16;
  localparam int W3_HI = 15;
  localparam int W3_LO = 0;

  localparam int TIMEOUT_W = 10;

endpackage

// File: rtl/sdram_initiator_if.sv
// Client req/ack bundle plus controller strobe/data bundle.
// master = client/controller side, slave = sdram_initiator.
interface sdram_initiator_if;

  logic        req;
  logic        req_we;
  logic        req_burst;
  logic [24:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_wtbt;
  logic        ack;
  logic [63:0] rdata;
  logic        err;

  logic [24:0] sd_addr;
  logic [15:0] sd_din;
  logic [1:0]  sd_wtbt;
  logic        sd_rd_type;
  logic        sd_rd;
  logic        sd_we;
  logic [63:0] sd_dout;
  logic        sd_ready;

  modport master (
    output req, req_we, req_burst,
    output req_addr, req_wdata, req_wtbt,
    input  ack, rdata, err,
    input  sd_addr, sd_din, sd_wtbt,
    input  sd_rd_type, sd_rd, sd_we,
    output sd_dout, sd_ready
  );

  modport slave (
    input  req, req_we, req_burst,
    input  req_addr, req_wdata, req_wtbt,
    output ack, rdata, err,
    output sd_addr, sd_din, sd_wtbt,
    output sd_rd_type, sd_rd, sd_we,
    input  sd_dout, sd_ready
  );

endinterface

// File: rtl/sdram_linebuf.sv
// One-line, four-word read buffer filled by burst reads.
module sdram_linebuf
  import sdram_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [24:1] lk_addr,
  input  logic        lk_rd,
  input  logic        lk_burst,
  input  logic        fill,
  input  logic [24:3] fill_tag,
  input  logic [63:0] fill_data,
  input  logic        inv,
  output logic        hit,
  output logic [63:0] hit_data
);

  logic        valid_q, valid_d;
  logic [24:3] tag_q, tag_d;
  logic [63:0] line_q, line_d;
  logic        tag_eq;
  logic [15:0] word;

  assign tag_eq = valid_q && (tag_q == lk_addr[24:3]);
  assign hit    = tag_eq && lk_rd;

  always_comb begin
    word = line_q[W0_HI:W0_LO];
    unique case (lk_addr[2:1])
      2'd0: word = line_q[W0_HI:W0_LO];
      2'd1: word = line_q[W1_HI:W1_LO];
      2'd2: word = line_q[W2_HI:W2_LO];
      2'd3: word = line_q[W3_HI:W3_LO];
      default: word = line_q[W0_HI:W0_LO];
    endcase
    hit_data = lk_burst ? line_q : {word, 48'h0};
  end

  // inv strobes at write acceptance, while req_addr still holds the write address
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    line_d  = line_q;
    if (fill) begin
      valid_d = 1'b1;
      tag_d   = fill_tag;
      line_d  = fill_data;
    end else if (inv && tag_eq) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: rtl/sdram_initiator.sv
// req/ack to edge-strobe bridge for the SDRAM controller CPU port.
// Define SDRAM_INIT_LINEBUF_EN to add the burst-filled line buffer.
module sdram_initiator
  import sdram_pkg::*;
#(
  parameter int GUARD_CYCLES = 2,
  parameter int TIMEOUT      = 1023
) (
  input logic              clk,
  input logic              nRESET,
  sdram_initiator_if.slave bus
);

  localparam int GC_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GC_W-1:0] GC_LAST = GC_W'(GUARD_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TO = TIMEOUT_W'(TIMEOUT);

  state_t               state_q, state_d;
  logic [GC_W-1:0]      gcnt_q, gcnt_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [63:0]          rdata_q, rdata_d;
  logic [24:0]          sd_addr_q, sd_addr_d;
  logic [15:0]          sd_din_q, sd_din_d;
  logic [1:0]           sd_wtbt_q, sd_wtbt_d;
  logic                 sd_rd_type_q, sd_rd_type_d;
  logic                 sd_rd_q, sd_rd_d;
  logic                 sd_we_q, sd_we_d;

  logic                 hit;
  logic [63:0]          hit_data;
  logic                 fill;
  logic                 inv;
  logic                 burst_rd;

  assign burst_rd = bus.req_burst && !bus.req_we;

  always_comb begin
    state_d      = state_q;
    gcnt_d       = gcnt_q;
    wdog_d       = wdog_q;
    ack_d        = 1'b0;
    err_d        = err_q;
    rdata_d      = rdata_q;
    sd_addr_d    = sd_addr_q;
    sd_din_d     = sd_din_q;
    sd_wtbt_d    = sd_wtbt_q;
    sd_rd_type_d = sd_rd_type_q;
    sd_rd_d      = sd_rd_q;
    sd_we_d      = sd_we_q;
    fill         = 1'b0;
    inv          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req && hit) begin
          state_d = DONE;
          ack_d   = 1'b1;
          rdata_d = hit_data;
        end else if (bus.req && bus.sd_ready) begin
          state_d      = GUARD;
          gcnt_d       = '0;
          sd_rd_d      = !bus.req_we;
          sd_we_d      = bus.req_we;
          sd_rd_type_d = burst_rd;
          sd_addr_d    = burst_rd ? {bus.req_addr[24:3], 3'b000}
                                  : bus.req_addr;
          sd_din_d     = bus.req_wdata;
          sd_wtbt_d    = bus.req_wtbt;
          inv          = bus.req_we;
        end
      end
      GUARD: begin
        if (gcnt_q == GC_LAST) begin
          state_d = WAIT;
          wdog_d  = '0;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      WAIT: begin
        // a ready seen on the expiry edge still counts as a clean finish
        if (bus.sd_ready || wdog_q == TO) begin
          state_d = DONE;
          ack_d   = 1'b1;
          sd_rd_d = 1'b0;
          sd_we_d = 1'b0;
          if (!bus.sd_ready) err_d = 1'b1;
          if (sd_rd_q) begin
            rdata_d = sd_rd_type_q ? bus.sd_dout
                                   : {bus.sd_dout[W0_HI:W0_LO], 48'h0};
          end
          fill = sd_rd_q && sd_rd_type_q;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q      <= IDLE;
      gcnt_q       <= '0;
      wdog_q       <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      sd_addr_q    <= '0;
      sd_din_q     <= '0;
      sd_wtbt_q    <= 2'b00;
      sd_rd_type_q <= 1'b0;
      sd_rd_q      <= 1'b0;
      sd_we_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      gcnt_q       <= gcnt_d;
      wdog_q       <= wdog_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      sd_addr_q    <= sd_addr_d;
      sd_din_q     <= sd_din_d;
      sd_wtbt_q    <= sd_wtbt_d;
      sd_rd_type_q <= sd_rd_type_d;
      sd_rd_q      <= sd_rd_d;
      sd_we_q      <= sd_we_d;
    end
  end

`ifdef SDRAM_INIT_LINEBUF_EN
  sdram_linebuf u_linebuf (
    .clk       (clk),
    .rst_n     (nRESET),
    .lk_addr   (bus.req_addr[24:1]),
    .lk_rd     (!bus.req_we),
    .lk_burst  (bus.req_burst),
    .fill      (fill),
    .fill_tag  (sd_addr_q[24:3]),
    .fill_data (bus.sd_dout),
    .inv       (inv),
    .hit       (hit),
    .hit_data  (hit_data)
  );
`else
  logic lb_unused;
  assign lb_unused = ^{fill, inv};
  assign hit       = 1'b0;
  assign hit_data  = '0;
`endif

  assign bus.ack        = ack_q;
  assign bus.err        = err_q;
  assign bus.rdata      = rdata_q;
  assign bus.sd_addr    = sd_addr_q;
  assign bus.sd_din     = sd_din_q;
  assign bus.sd_wtbt    = sd_wtbt_q;
  assign bus.sd_rd_type = sd_rd_type_q;
  assign bus.sd_rd      = sd_rd_q;
  assign bus.sd_we      = sd_we_q;

endmodule

// File: tb/tb_sdram_initiator.sv
// Bench for sdram_initiator: controller model, vector table,
// short-circuit, watchdog and mid-operation reset sequences.
module tb_sdram_initiator;

`ifdef SDRAM_INIT_LINEBUF_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  typedef enum int {M_NORMAL, M_SHORT, M_DEAD} mode_t;

  typedef struct {
    logic        we;
    logic        burst;
    logic [24:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wtbt;
    bit          hit;
    logic [24:0] exp_sa;
    logic [63:0] exp_rd;
  } vec_t;

  typedef struct {
    bit          got;
    int          n;
    logic [63:0] rd;
    logic [24:0] sa;
    logic [15:0] din;
    logic [1:0]  wtbt;
    logic        ack2;
    int          rdr;
    int          wer;
  } res_t;

  bit   clk = 1'b0;
  logic nRESET;
  always #5 clk = ~clk;

  sdram_initiator_if bus ();

  sdram_initiator dut (
    .clk    (clk),
    .nRESET (nRESET),
    .bus    (bus.slave)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // controller model
  mode_t       mode = M_NORMAL;
  logic [15:0] wmem [int];
  bit          m_init = 1'b0;
  bit          m_rd_p = 1'b0;
  bit          m_we_p = 1'b0;
  int          busy = 0;
  logic [63:0] pend = '0;
  int          m_wi;
  logic [15:0] m_old;

  function automatic logic [15:0] base_w(input int i);
    case (i)
      'h80:    return 16'hA5A5;
      'h84:    return 16'h1111;
      'h85:    return 16'h2222;
      'h86:    return 16'h3333;
      'h87:    return 16'h4444;
      default: return 16'h1000 | 16'(i);
    endcase
  endfunction

  function automatic logic [15:0] mw(input int i);
    if (wmem.exists(i)) return wmem[i];
    return base_w(i);
  endfunction

  function automatic logic [63:0] rd_fn(input logic [24:0] a,
                                        input logic b);
    int i;
    i = int'(a[24:1]);
    if (b) return {mw(i), mw(i + 1), mw(i + 2), mw(i + 3)};
    return {mw(i), 48'hDEAD_BEEF_CAFE};
  endfunction

  always @(posedge clk) begin
    m_rd_p <= bus.sd_rd;
    m_we_p <= bus.sd_we;
    if (!m_init) begin
      bus.sd_ready <= 1'b1;
      bus.sd_dout  <= '0;
      m_init       <= 1'b1;
    end else if ((bus.sd_rd && !m_rd_p) || (bus.sd_we && !m_we_p)) begin
      if (bus.sd_we) begin
        m_wi  = int'(bus.sd_addr[24:1]);
        m_old = mw(m_wi);
        wmem[m_wi] = {bus.sd_wtbt[1] ? bus.sd_din[15:8] : m_old[15:8],
                      bus.sd_wtbt[0] ? bus.sd_din[7:0] : m_old[7:0]};
      end
      if (mode == M_SHORT) begin
        bus.sd_dout <= rd_fn(bus.sd_addr, bus.sd_rd_type);
      end else begin
        bus.sd_ready <= 1'b0;
        busy         <= 3;
        pend         <= rd_fn(bus.sd_addr, bus.sd_rd_type);
      end
    end else if (busy > 1) begin
      busy <= busy - 1;
    end else if (mode != M_DEAD && !bus.sd_ready) begin
      bus.sd_ready <= 1'b1;
      bus.sd_dout  <= pend;
      busy         <= 0;
    end
  end

  // strobe monitor: rise counts and low-run length before each sd_rd rise
  int rd_rises = 0;
  int we_rises = 0;
  int lowrun = 0;
  int gaps[$];
  bit mon_rd_p = 1'b0;
  bit mon_we_p = 1'b0;

  always @(negedge clk) begin
    if (bus.sd_rd && !mon_rd_p) begin
      rd_rises <= rd_rises + 1;
      gaps.push_back(lowrun);
    end
    if (bus.sd_we && !mon_we_p) we_rises <= we_rises + 1;
    lowrun   <= bus.sd_rd ? 0 : lowrun + 1;
    mon_rd_p <= bus.sd_rd;
    mon_we_p <= bus.sd_we;
  end

  task automatic set_req(input vec_t v);
    bus.req_we    = v.we;
    bus.req_burst = v.burst;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_wtbt  = v.wtbt;
  endtask

  task automatic run_req(input vec_t v, input int limit, output res_t r);
    int r0;
    int w0;
    r0 = rd_rises;
    w0 = we_rises;
    set_req(v);
    bus.req = 1'b1;
    r.n   = 0;
    r.got = 1'b0;
    while (!r.got && r.n < limit) begin
      @(posedge clk);
      r.n++;
      @(negedge clk);
      r.got = (bus.ack === 1'b1);
    end
    r.rd   = bus.rdata;
    r.sa   = bus.sd_addr;
    r.din  = bus.sd_din;
    r.wtbt = bus.sd_wtbt;
    bus.req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    r.ack2 = bus.ack;
    r.rdr  = rd_rises - r0;
    r.wer  = we_rises - w0;
  endtask

  task automatic check_vec(input string nm, input vec_t v,
                           input int lat, input res_t r);
    chk({nm, "_ack"}, 64'(r.got), 64'd1);
    chk({nm, "_rdata"}, r.rd, v.exp_rd);
    chk({nm, "_lat"}, 64'(r.n), 64'(lat));
    chk({nm, "_rd_strobes"}, 64'(r.rdr), (v.hit || v.we) ? 64'd0 : 64'd1);
    chk({nm, "_we_strobes"}, 64'(r.wer), v.we ? 64'd1 : 64'd0);
    chk({nm, "_ack_pulse"}, 64'(r.ack2), 64'd0);
    if (!v.hit) chk({nm, "_sd_addr"}, 64'(r.sa), 64'(v.exp_sa));
    if (v.we) begin
      chk({nm, "_sd_din"}, 64'(r.din), 64'(v.wdata));
      chk({nm, "_sd_wtbt"}, 64'(r.wtbt), 64'(v.wtbt));
    end
  endtask

  vec_t vt [10];
  vec_t vx;
  res_t r;
  int   base;
  int   r0;
  int   acks;
  int   cyc;
  bit   got;

  initial begin
    vt[0] = '{0, 0, 25'h100, 16'h0, 2'b00, 1'b0, 25'h100, 64'hA5A5_0000_0000_0000};
    vt[1] = '{0, 1, 25'h10E, 16'h0, 2'b00, 1'b0, 25'h108, 64'h1111_2222_3333_4444};
    vt[2] = '{0, 0, 25'h10C, 16'h0, 2'b00, LB,   25'h10C, 64'h3333_0000_0000_0000};
    vt[3] = '{0, 1, 25'h108, 16'h0, 2'b00, LB,   25'h108, 64'h1111_2222_3333_4444};
    vt[4] = '{1, 0, 25'h10A, 16'hBEEF, 2'b11, 1'b0, 25'h10A, 64'h1111_2222_3333_4444};
    vt[5] = '{0, 1, 25'h108, 16'h0, 2'b00, 1'b0, 25'h108, 64'h1111_BEEF_3333_4444};
    vt[6] = '{0, 0, 25'h10A, 16'h0, 2'b00, LB,   25'h10A, 64'hBEEF_0000_0000_0000};
    vt[7] = '{1, 0, 25'h200, 16'h00C3, 2'b01, 1'b0, 25'h200, 64'hBEEF_0000_0000_0000};
    vt[8] = '{0, 0, 25'h10E, 16'h0, 2'b00, LB,   25'h10E, 64'h4444_0000_0000_0000};
    vt[9] = '{0, 0, 25'h200, 16'h0, 2'b00, 1'b0, 25'h200, 64'h11C3_0000_0000_0000};

    bus.req = 1'b0;
    set_req(vt[0]);
    nRESET = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 64'(bus.ack), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_strobes", 64'({bus.sd_rd, bus.sd_we, bus.sd_rd_type}), 64'd0);
    chk("rst_rdata", bus.rdata, 64'd0);
    chk("rst_sd_bus", 64'({bus.sd_addr, bus.sd_din, bus.sd_wtbt}), 64'd0);
    nRESET = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 10; k++) begin
      run_req(vt[k], 50, r);
      check_vec($sformatf("v%0d", k), vt[k], vt[k].hit ? 1 : 6, r);
    end

    // controller short-circuit: sd_ready never drops
    mode = M_SHORT;
    vx = '{0, 0, 25'h104, 16'h0, 2'b00, 1'b0, 25'h104, 64'h1082_0000_0000_0000};
    run_req(vx, 50, r);
    check_vec("short", vx, 4, r);

    base = gaps.size();
    r0   = rd_rises;
    acks = 0;
    set_req(vt[0]);
    bus.req = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ack === 1'b1) acks++;
    end
    bus.req = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("b2b_acks", 64'(acks), 64'd3);
    chk("b2b_strobes", 64'(rd_rises - r0), 64'd3);
    chk("b2b_gap_count", 64'(gaps.size() - base), 64'd3);
    if (gaps.size() >= base + 3) begin
      chk("b2b_gap1_ge2", 64'(gaps[base + 1] >= 2), 64'd1);
      chk("b2b_gap2_ge2", 64'(gaps[base + 2] >= 2), 64'd1);
    end

    // watchdog: controller never answers
    mode = M_DEAD;
    vx = '{0, 0, 25'h102, 16'h0, 2'b00, 1'b0, 25'h102, 64'h0};
    run_req(vx, 2000, r);
    chk("wd_ack", 64'(r.got), 64'd1);
    chk("wd_lat", 64'(r.n), 64'd1027);
    chk("wd_err", 64'(bus.err), 64'd1);
    mode = M_NORMAL;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    vx = '{0, 0, 25'h104, 16'h0, 2'b00, 1'b0, 25'h104, 64'h1082_0000_0000_0000};
    run_req(vx, 50, r);
    check_vec("post_wd", vx, 6, r);
    chk("wd_err_sticky", 64'(bus.err), 64'd1);

    // reset while waiting on a dead controller
    mode = M_DEAD;
    vx = '{0, 0, 25'h102, 16'h0, 2'b00, 1'b0, 25'h102, 64'h1081_0000_0000_0000};
    set_req(vx);
    bus.req = 1'b1;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_rst_sd_rd", 64'(bus.sd_rd), 64'd1);
    nRESET = 1'b0;
    #1;
    chk("mid_rst_sd_rd", 64'(bus.sd_rd), 64'd0);
    chk("mid_rst_ack", 64'(bus.ack), 64'd0);
    chk("mid_rst_err", 64'(bus.err), 64'd0);
    chk("mid_rst_rdata", bus.rdata, 64'd0);
    chk("mid_rst_sd_addr", 64'(bus.sd_addr), 64'd0);
    @(negedge clk);
    nRESET = 1'b1;
    r0 = rd_rises;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("rst_hold_no_strobe", 64'(rd_rises - r0), 64'd0);
    mode = M_NORMAL;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 50) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      got = (bus.ack === 1'b1);
    end
    chk("rst_resume_ack", 64'(got), 64'd1);
    chk("rst_resume_rdata", bus.rdata, vx.exp_rd);
    bus.req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_resume_strobes", 64'(rd_rises - r0), 64'd1);

    vx = '{0, 0, 25'h10C, 16'h0, 2'b00, 1'b0, 25'h10C, 64'h3333_0000_0000_0000};
    run_req(vx, 50, r);
    check_vec("post_rst_miss", vx, 6, r);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
